// File: rtl/sigmoid_prime_arbiter.sv
// Round-robin arbiter that shares one fixed-latency sigmoid-prime unit among N_REQ lanes,
// with credit-based issue and a tagged result FIFO. Optional counters: SIGMOID_ARB_PERF_EN.
module sigmoid_prime_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int LAT        = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic [15:0]           spu_in,
    input  logic [15:0]           spu_out,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_data,
    input  logic                  rsp_ready,
    output logic                  busy
`ifdef SIGMOID_ARB_PERF_EN
    ,
    input  logic                  perf_clr,
    output logic [31:0]           perf_grants,
    output logic [31:0]           perf_stalls
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  rr_ptr_r;
    logic [15:0]      spu_in_r;
    logic [LAT:0]     tag_vld_r;
    logic [ID_W-1:0]  tag_id_r [0:LAT];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] inflight_r;
    logic             busy_r;
    logic [ID_W-1:0]  id_mem_r   [0:FIFO_DEPTH-1];
    logic [15:0]      data_mem_r [0:FIFO_DEPTH-1];

    logic             found_s;
    logic             hit_s;
    logic [ID_W-1:0]  win_s;
    logic [15:0]      sel_data_s;
    logic             credit_s;
    logic             grant_s;
    logic             capture_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [CNT_W-1:0] inflight_nxt_s;

    // Credit covers everything already issued plus everything buffered, so a capture always has room.
    assign credit_s  = ({1'b0, inflight_r} + {1'b0, count_r}) < (CNT_W+1)'(FIFO_DEPTH);
    // Tag stage 0 lines up with spu_in; stage LAT lines up with the unit's registered result.
    assign capture_s = tag_vld_r[LAT];
    assign pop_s     = (count_r != CNT_W'(0)) & rsp_ready;

    // Round-robin search from rr_ptr, operand mux for the winner, grant gated by credit and reset.
    always_comb begin
        found_s    = 1'b0;
        hit_s      = 1'b0;
        win_s      = '0;
        sel_data_s = 16'h0000;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                hit_s   = !found_s && req_valid[j] && (j == ((int'(rr_ptr_r) + i) % N_REQ));
                win_s   = hit_s ? ID_W'(j) : win_s;
                found_s = found_s | hit_s;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            sel_data_s = (win_s == ID_W'(j)) ? req_data[16*j +: 16] : sel_data_s;
        end
        grant_s   = found_s & credit_s & rst;
        req_ready = grant_s ? (N_REQ'(1) << win_s) : '0;
    end

    // Next-state for FIFO occupancy and in-flight count.
    always_comb begin
        count_nxt_s    = count_r;
        inflight_nxt_s = inflight_r;
        case ({capture_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        case ({grant_s, capture_s})
            2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
            2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
    end

    // Issue register: operand to the unit and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spu_in_r <= 16'h0000;
            rr_ptr_r <= '0;
        end else if (grant_s) begin
            spu_in_r <= sel_data_s;
            rr_ptr_r <= (win_s == ID_W'(N_REQ-1)) ? '0 : win_s + ID_W'(1);
        end
    end

    // Tag pipe shadowing the shared unit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_r <= '0;
            for (int k = 0; k <= LAT; k++) tag_id_r[k] <= '0;
        end else begin
            tag_vld_r   <= {tag_vld_r[LAT-1:0], grant_s};
            tag_id_r[0] <= win_s;
            for (int k = 1; k <= LAT; k++) tag_id_r[k] <= tag_id_r[k-1];
        end
    end

    // Result FIFO storage, pointers, counters and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            inflight_r <= '0;
            busy_r     <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                id_mem_r[k]   <= '0;
                data_mem_r[k] <= 16'h0000;
            end
        end else begin
            if (capture_s) begin
                id_mem_r[wr_ptr_r]   <= tag_id_r[LAT];
                data_mem_r[wr_ptr_r] <= spu_out;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_nxt_s;
            inflight_r <= inflight_nxt_s;
            busy_r     <= (inflight_nxt_s != CNT_W'(0)) | (count_nxt_s != CNT_W'(0));
        end
    end

    assign spu_in    = spu_in_r;
    assign rsp_valid = (count_r != CNT_W'(0));
    assign rsp_id    = id_mem_r[rd_ptr_r];
    assign rsp_data  = data_mem_r[rd_ptr_r];
    assign busy      = busy_r;

`ifdef SIGMOID_ARB_PERF_EN
    logic [31:0] perf_grants_r;
    logic [31:0] perf_stalls_r;

    // Saturating grant and credit-stall counters; clear wins over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_grants_r <= 32'h0000_0000;
            perf_stalls_r <= 32'h0000_0000;
        end else if (perf_clr) begin
            perf_grants_r <= 32'h0000_0000;
            perf_stalls_r <= 32'h0000_0000;
        end else begin
            if (grant_s && (perf_grants_r != 32'hFFFF_FFFF)) begin
                perf_grants_r <= perf_grants_r + 32'd1;
            end
            if (found_s && !credit_s && (perf_stalls_r != 32'hFFFF_FFFF)) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end
        end
    end

    assign perf_grants = perf_grants_r;
    assign perf_stalls = perf_stalls_r;
`endif

endmodule

// File: tb/tb_sigmoid_prime_arbiter.sv
// Scoreboard bench for sigmoid_prime_arbiter: the stimulus pushes expected {lane, result}
// on each expected grant; an independent monitor pops and compares on every rsp handshake.
module tb_sigmoid_prime_arbiter;

    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int LAT        = 1;
    localparam int FIFO_DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N_REQ-1:0]     lane_valid;
    logic [15:0]          lane_data [N_REQ];
    logic [16*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]     req_ready;
    logic [15:0]          spu_in;
    logic [15:0]          spu_out = 16'h0000;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_data;
    logic                 rsp_ready;
    logic                 busy;

    logic [ID_W+15:0]     sb_q [$];
    int                   n_checks = 0;
    int                   n_fail   = 0;

    sigmoid_prime_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(lane_valid), .req_data(req_data), .req_ready(req_ready),
        .spu_in(spu_in), .spu_out(spu_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared unit: byte swap then XOR, one register stage.
    function automatic logic [15:0] unit_f(input logic [15:0] x);
        return {x[7:0], x[15:8]} ^ 16'h5A5A;
    endfunction

    always @(posedge clk) spu_out <= unit_f(spu_in);

    always_comb begin
        for (int i = 0; i < N_REQ; i++) req_data[16*i +: 16] = lane_data[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted response must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [ID_W+15:0] exp_e;
        if (rst && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %0h with empty scoreboard", rsp_id, rsp_data);
            end else begin
                exp_e = sb_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(exp_e[ID_W+15:16]));
                check("rsp_data", 32'(rsp_data), 32'(exp_e[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: check the expected grant, record expected results, advance granted lane data.
    task automatic step(input logic [N_REQ-1:0] exp_rdy, input bit chk_rv);
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (chk_rv) check("rsp_valid_stream", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_rdy[i] && lane_valid[i]) sb_q.push_back({ID_W'(i), unit_f(lane_data[i])});
        end
        tick();
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_rdy[i] && lane_valid[i]) lane_data[i] = lane_data[i] + 16'h0111;
        end
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int t = 0; t < 40 && (sb_q.size() != 0 || busy); t++) tick();
        @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        tick();
    endtask

    // Single lane streams until credit runs out: FIFO_DEPTH grants, then stalls.
    task automatic fill(input int lane);
        lane_valid = N_REQ'(1) << lane;
        for (int k = 0; k < FIFO_DEPTH; k++) step(N_REQ'(1) << lane, 1'b0);
        for (int k = 0; k < 3; k++) step(4'b0000, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lane_valid = 4'b0000;
        rsp_ready  = 1'b0;
        for (int i = 0; i < N_REQ; i++) lane_data[i] = 16'h0000;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_spu_in", 32'(spu_in), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single lane2 request, LAT=1: result three cycles after the handshake.
        lane_data[2] = 16'h1234;
        lane_valid   = 4'b0100;
        step(4'b0100, 1'b0);
        lane_valid = 4'b0000;
        @(negedge clk);
        check("t1_spu_in", 32'(spu_in), 32'h1234);
        check("t1_rv_c1", 32'(rsp_valid), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("t1_rv_c2", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t1_rv_c3", 32'(rsp_valid), 32'd1);
        check("t1_id", 32'(rsp_id), 32'd2);
        check("t1_data", 32'(rsp_data), 32'h6E48);
        tick();
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t1_busy_drop", 32'(busy), 32'd0);
        check("t1_rv_drop", 32'(rsp_valid), 32'd0);
        tick();

        // All lanes valid: rr_ptr is 3 after lane2, so grants run 3,0,1,2,...
        for (int i = 0; i < N_REQ; i++) lane_data[i] = 16'h1000 * 16'(i + 1);
        lane_valid = 4'b1111;
        for (int k = 0; k < 10; k++) step(4'b0001 << ((3 + k) % 4), k >= 3);
        lane_valid = 4'b0000;
        drain();

        // Backpressure: lane0 gets exactly FIFO_DEPTH grants, then the FIFO drains in order.
        rsp_ready = 1'b0;
        fill(0);
        lane_valid = 4'b0000;
        drain();

        // Full FIFO released with lane1 valid: one empty cycle, then grant and pop every cycle.
        rsp_ready = 1'b0;
        fill(1);
        rsp_ready = 1'b1;
        step(4'b0000, 1'b1);
        for (int k = 0; k < 6; k++) step(4'b0010, 1'b1);
        lane_valid = 4'b0000;
        drain();

        // Reset with two in flight and two buffered.
        rsp_ready  = 1'b0;
        lane_valid = 4'b0100;
        for (int k = 0; k < 4; k++) step(4'b0100, 1'b0);
        rst = 1'b0;
        #1;
        check("r5_req_ready", 32'(req_ready), 32'd0);
        check("r5_spu_in", 32'(spu_in), 32'd0);
        check("r5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("r5_rsp_id", 32'(rsp_id), 32'd0);
        check("r5_rsp_data", 32'(rsp_data), 32'd0);
        check("r5_busy", 32'(busy), 32'd0);
        sb_q.delete();
        lane_valid = 4'b0000;
        tick();
        rst          = 1'b1;
        lane_data[3] = 16'hBEEF;
        lane_valid   = 4'b1000;
        step(4'b1000, 1'b0);
        lane_valid = 4'b0000;
        drain();

        // rr_ptr must return to 0 on reset: left at 3, then lanes 1 and 3 compete.
        lane_valid = 4'b0100;
        step(4'b0100, 1'b0);
        lane_valid = 4'b0000;
        rst = 1'b0;
        sb_q.delete();
        tick();
        rst        = 1'b1;
        lane_valid = 4'b1010;
        step(4'b0010, 1'b0);
        lane_valid = 4'b0000;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
